// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: widths, register-zero specifier
// and the ALUControl encodings understood by the 32-bit ALU.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // ALU operation encodings; 0 is the ALU default (result 0) used by bubbles
    typedef enum logic [ALUC_W-1:0] {
        ALU_NOP  = 5'b00000,
        ALU_ADD  = 5'b00001,
        ALU_SUB  = 5'b00010,
        ALU_AND  = 5'b00011,
        ALU_OR   = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_NOR  = 5'b00110,
        ALU_SLT  = 5'b00111,
        ALU_SLTU = 5'b01000,
        ALU_SLL  = 5'b01001,
        ALU_SRL  = 5'b01010,
        ALU_SRA  = 5'b01011,
        ALU_SLLV = 5'b01100,
        ALU_SRLV = 5'b01101,
        ALU_SRAV = 5'b01110,
        ALU_LUI  = 5'b01111,
        ALU_BEQ  = 5'b10000,
        ALU_BNE  = 5'b10001,
        ALU_BLT  = 5'b10010
    } alu_op_e;

    // Bit position of the shift amount inside ALU operand A
    localparam int SHAMT_LSB = 7;

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding select for one source register: the youngest producer
// (EX/MEM) wins over MEM/WB, and register 0 is never forwarded.
module forward_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] spec_reg,
    input  logic [DATA_W-1:0] reg_value,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [DATA_W-1:0] ex_mem_result,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic [DATA_W-1:0] fwd_value
);
    import mips_pkg::*;

    logic not_zero;
    logic hit_ex_mem;
    logic hit_mem_wb;

    assign not_zero   = (spec_reg != REG_AW'(REG_ZERO));
    assign hit_ex_mem = not_zero & ex_mem_reg_write & (ex_mem_rd == spec_reg);
    assign hit_mem_wb = not_zero & mem_wb_reg_write & (mem_wb_rd == spec_reg);

    // Priority select: EX/MEM, then MEM/WB, then the register-file value
    always_comb begin
        fwd_value = reg_value;
        if (hit_ex_mem) begin
            fwd_value = ex_mem_result;
        end else if (hit_mem_wb) begin
            fwd_value = mem_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Holds decoded operands and
// control, resolves forwarding on the registered specifiers, formats the
// shift amount into operand A and raises the load-use stall request.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] IdReadData1,
    input  logic [DATA_W-1:0] IdReadData2,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [4:0]        IdShamt,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    input  logic [REG_AW-1:0] IdRd,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemToReg,
    input  logic              IdBranch,
    input  logic              IdALUSrc,
    input  logic              IdRegDst,
    input  logic              IdShiftSel,
    input  logic [ALUC_W-1:0] IdALUControl,
    input  logic              ExMemRegWrite,
    input  logic [REG_AW-1:0] ExMemRd,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic              MemWbRegWrite,
    input  logic [REG_AW-1:0] MemWbRd,
    input  logic [DATA_W-1:0] MemWbData,
    output logic [DATA_W-1:0] ALUA,
    output logic [DATA_W-1:0] ALUB,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_AW-1:0] DestReg,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemToReg,
    output logic              Branch,
    output logic              Valid,
    output logic              HazardStall
);
    import mips_pkg::*;

    // Data and specifier registers
    logic [DATA_W-1:0] read_data1_q;
    logic [DATA_W-1:0] read_data2_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] dest_q;

    // Control registers
    logic              valid_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;
    logic              branch_q;
    logic              alu_src_q;
    logic              shift_sel_q;
    logic [ALUC_W-1:0] alu_control_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] shift_operand;

    // Data path registers: cleared on reset, held on stall, left alone by a
    // flush because a bubble never consumes them.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            read_data1_q <= '0;
            read_data2_q <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
        end else if (!Flush && !Stall) begin
            read_data1_q <= IdReadData1;
            read_data2_q <= IdReadData2;
            imm_q        <= IdImm;
            shamt_q      <= IdShamt;
            rs_q         <= IdRs;
            rt_q         <= IdRt;
            dest_q       <= IdRegDst ? IdRd : IdRt;
        end
    end

    // Control registers: reset and flush both produce a bubble; flush wins
    // over stall so a held instruction can still be squashed.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            shift_sel_q   <= 1'b0;
            alu_control_q <= ALUC_W'(ALU_NOP);
        end else if (!Stall) begin
            valid_q       <= 1'b1;
            reg_write_q   <= IdRegWrite;
            mem_read_q    <= IdMemRead;
            mem_write_q   <= IdMemWrite;
            mem_to_reg_q  <= IdMemToReg;
            branch_q      <= IdBranch;
            alu_src_q     <= IdALUSrc;
            shift_sel_q   <= IdShiftSel;
            alu_control_q <= IdALUControl;
        end
    end

    forward_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .spec_reg         (rs_q),
        .reg_value        (read_data1_q),
        .ex_mem_reg_write (ExMemRegWrite),
        .ex_mem_rd        (ExMemRd),
        .ex_mem_result    (ExMemResult),
        .mem_wb_reg_write (MemWbRegWrite),
        .mem_wb_rd        (MemWbRd),
        .mem_wb_data      (MemWbData),
        .fwd_value        (fwd_rs)
    );

    forward_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .spec_reg         (rt_q),
        .reg_value        (read_data2_q),
        .ex_mem_reg_write (ExMemRegWrite),
        .ex_mem_rd        (ExMemRd),
        .ex_mem_result    (ExMemResult),
        .mem_wb_reg_write (MemWbRegWrite),
        .mem_wb_rd        (MemWbRd),
        .mem_wb_data      (MemWbData),
        .fwd_value        (fwd_rt)
    );

    // The ALU takes the shift amount from A[11:7]
    assign shift_operand = {{(DATA_W-SHAMT_LSB-5){1'b0}}, shamt_q, {SHAMT_LSB{1'b0}}};

    // Operand selection for the ALU and the store-data path
    always_comb begin
        ALUA = shift_sel_q ? shift_operand : fwd_rs;
        ALUB = alu_src_q ? imm_q : fwd_rt;
    end

    assign StoreData  = fwd_rt;
    assign ALUControl = alu_control_q;
    assign DestReg    = dest_q;
    assign RegWrite   = reg_write_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign MemToReg   = mem_to_reg_q;
    assign Branch     = branch_q;
    assign Valid      = valid_q;

    // A load in this stage whose target is read by the instruction in decode
    assign HazardStall = valid_q & mem_read_q & (rt_q != REG_AW'(REG_ZERO))
                       & ((rt_q == IdRs) | (rt_q == IdRt));

endmodule
